// File: rtl/cdc_pkg.sv
// Shared constants and types for the slow-to-fast level crossing.
// Build option: define CDC_EDGE_FILTER_EN to enable the level filter.
package cdc_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_CNT_W    = 4;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_pulse_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into fast_clk.
// Stage 0 samples d directly; q is the last stage.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic fast_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    // Shift the raw level through the synchronizer flops.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_edge_detector.sv
// Synchronizes slow_data into fast_clk and emits one-cycle edge pulses.
// Build option: define CDC_EDGE_FILTER_EN for a FILTER_CYCLES level filter.
module cdc_edge_detector
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic fast_clk,
    input  logic rst,
    input  logic slow_data,
    output logic data_rise,
    output logic data_fall,
    output logic data_sync
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("SYNC_STAGES must be in 2..4");
    end

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
        $error("FILTER_CYCLES must be in 1..15");
    end

    logic        w_sync;
    logic        r_level;
    logic        r_prev;
    edge_pulse_t r_pulse;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .fast_clk (fast_clk),
        .rst      (rst),
        .d        (slow_data),
        .q        (w_sync)
    );

`ifdef CDC_EDGE_FILTER_EN
    localparam logic [FILTER_CNT_W-1:0] L_FILT = FILTER_CNT_W'(FILTER_CYCLES);

    logic [FILTER_CNT_W-1:0] r_cnt;

    // Accept a new level only after it persists past the filter window.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == L_FILT) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else if (r_cnt != '1) begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end
`else
    // Accepted level is the registered synchronizer output.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
        end else begin
            r_level <= w_sync;
        end
    end
`endif

    // Compare against the previous accepted level to form edge pulses.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_pulse <= '0;
        end else begin
            r_prev       <= r_level;
            r_pulse.rise <= r_level & ~r_prev;
            r_pulse.fall <= ~r_level & r_prev;
        end
    end

    assign data_rise = r_pulse.rise;
    assign data_fall = r_pulse.fall;
    assign data_sync = r_level;

endmodule

// File: tb/tb_cdc_edge_detector.sv
// Scoreboard bench for cdc_edge_detector.
// Expected pulses/levels are queued when slow_data is driven.
module tb_cdc_edge_detector;
    import cdc_pkg::*;

    localparam int STG = 2;
`ifdef CDC_EDGE_FILTER_EN
    localparam int FILT = 3;
`else
    localparam int FILT = 0;
`endif

    typedef struct {
        int          due;
        edge_pulse_t p;
    } pulse_ev_t;

    typedef struct {
        int   due;
        logic lvl;
    } sync_ev_t;

    logic fast_clk = 1'b0;
    logic rst;
    logic slow_data;
    logic data_rise;
    logic data_fall;
    logic data_sync;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_en = 1'b0;
    logic        exp_sync = 1'b0;
    logic        tb_acc = 1'b0;
    edge_pulse_t m_exp;
    pulse_ev_t   pq[$];
    sync_ev_t    sq[$];

    cdc_edge_detector #(
        .SYNC_STAGES   (STG),
        .FILTER_CYCLES (3)
    ) dut (
        .fast_clk  (fast_clk),
        .rst       (rst),
        .slow_data (slow_data),
        .data_rise (data_rise),
        .data_fall (data_fall),
        .data_sync (data_sync)
    );

    always #10 fast_clk = ~fast_clk;

    always @(posedge fast_clk) cyc <= cyc + 1;

    task automatic check(string tag, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called on a falling edge: the new level is first sampled at cyc+1.
    task automatic drive(logic v, int hold);
        int e0;
        slow_data = v;
        e0 = cyc + 1;
        if (v != tb_acc && (FILT == 0 || hold > FILT)) begin
            tb_acc = v;
            sq.push_back('{due: e0 + STG + FILT, lvl: v});
            pq.push_back('{due: e0 + STG + 1 + FILT,
                           p: '{rise: v, fall: !v}});
        end
        repeat (hold) @(negedge fast_clk);
    endtask

    always @(negedge fast_clk) begin
        if (mon_en) begin
            if (sq.size() > 0 && sq[0].due == cyc) begin
                exp_sync = sq[0].lvl;
                void'(sq.pop_front());
            end
            m_exp = '0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                m_exp = pq[0].p;
                void'(pq.pop_front());
            end
            check("sync", int'(data_sync), int'(exp_sync));
            check("rise", int'(data_rise), int'(m_exp.rise));
            check("fall", int'(data_fall), int'(m_exp.fall));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        slow_data = 1'b0;
        #35;
        check("rst_rise", int'(data_rise), 0);
        check("rst_fall", int'(data_fall), 0);
        check("rst_sync", int'(data_sync), 0);
        @(negedge fast_clk);
        rst = 1'b0;
        mon_en = 1'b1;

        drive(1'b0, 6);
        drive(1'b1, 8);
        drive(1'b0, 8);
        drive(1'b1, 2);
        drive(1'b0, 8);
        for (int i = 0; i < 6; i++) begin
            drive(logic'(i % 2 == 0), int'($urandom_range(2, 6)));
        end
        drive(1'b0, 12);

        drive(1'b1, 0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge fast_clk);
            #1;
            if (data_rise) begin
                seen = 1'b1;
                break;
            end
        end
        check("rise_seen", int'(seen), 1);
        #2;
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        check("async_rise", int'(data_rise), 0);
        check("async_fall", int'(data_fall), 0);
        check("async_sync", int'(data_sync), 0);
        pq.delete();
        sq.delete();
        exp_sync = 1'b0;
        tb_acc = 1'b0;
        repeat (2) @(posedge fast_clk);
        #1;
        check("hold_rise", int'(data_rise), 0);
        check("hold_sync", int'(data_sync), 0);
        @(negedge fast_clk);
        rst = 1'b0;
        mon_en = 1'b1;
        drive(1'b1, 12);
        drive(1'b0, 12);

        mon_en = 1'b0;
        check("pq_empty", pq.size(), 0);
        check("sq_empty", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
